// File: rtl/reg_bus_arbiter.sv
// Round-robin arbiter that serialises NREQ requesters onto a single register slave.
// Each access runs IDLE -> ACCESS -> RESP, so one transaction completes every three cycles.
module reg_bus_arbiter #(
   parameter int NREQ = 4,
   parameter int DW   = 16
) (
   input  logic                    clk,
   input  logic                    rstn,
   input  logic [NREQ-1:0]         req,
   input  logic [NREQ-1:0]         req_wr,
   input  logic [NREQ*DW-1:0]      req_wdata,
   output logic [NREQ-1:0]         ack,
   output logic [DW-1:0]           ack_rdata,
   output logic                    busy,
   output logic [$clog2(NREQ)-1:0] grant_id,
   output logic                    m_sel,
   output logic                    m_wr,
   output logic [DW-1:0]           m_wdata,
   input  logic [DW-1:0]           m_rdata
);

   localparam int IW = $clog2(NREQ);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   state_t          state, state_nxt;
   logic [IW-1:0]   rr_ptr, rr_ptr_nxt;
   logic [IW-1:0]   grant_id_nxt;
   logic [NREQ-1:0] ack_nxt;
   logic [DW-1:0]   ack_rdata_nxt;
   logic            busy_nxt;
   logic            m_sel_nxt;
   logic            m_wr_nxt;
   logic [DW-1:0]   m_wdata_nxt;

   // Round-robin search: one extra bit holds rr_ptr + offset before wrapping modulo NREQ.
   logic [IW:0]     cand;
   logic            pick_valid;
   logic [IW-1:0]   pick_idx;

   // NOTE: every combinational output is given a default before any branch, so no latches are inferred.
   always_comb begin
      cand       = '0;
      pick_valid = 1'b0;
      pick_idx   = '0;
      // Walk from the farthest offset down so the closest requester to rr_ptr wins.
      for (int i = NREQ - 1; i >= 0; i--) begin
         cand = {1'b0, rr_ptr} + (IW+1)'(i);
         if (cand >= (IW+1)'(NREQ)) begin
            cand = cand - (IW+1)'(NREQ);
         end
         if (req[cand[IW-1:0]]) begin
            pick_valid = 1'b1;
            pick_idx   = cand[IW-1:0];
         end
      end
   end

   always_comb begin
      state_nxt     = state;
      rr_ptr_nxt    = rr_ptr;
      grant_id_nxt  = grant_id;
      ack_nxt       = '0;
      ack_rdata_nxt = '0;
      busy_nxt      = 1'b0;
      m_sel_nxt     = 1'b0;
      m_wr_nxt      = 1'b0;
      m_wdata_nxt   = '0;

      unique case (state)
         IDLE: begin
            if (pick_valid) begin
               grant_id_nxt = pick_idx;
               m_sel_nxt    = 1'b1;
               m_wr_nxt     = req_wr[pick_idx];
               m_wdata_nxt  = req_wdata[pick_idx*DW +: DW];
               busy_nxt     = 1'b1;
               state_nxt    = ACCESS;
            end
         end

         ACCESS: begin
            ack_nxt = NREQ'(1) << grant_id;
            if (!m_wr) begin
               ack_rdata_nxt = m_rdata;
            end
            rr_ptr_nxt = (grant_id == IW'(NREQ - 1)) ? '0 : grant_id + IW'(1);
            busy_nxt   = 1'b1;
            state_nxt  = RESP;
         end

         RESP: begin
            state_nxt = IDLE;
         end

         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // NOTE: state and outputs use non-blocking assignments; reset is sampled only on the clock edge.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state     <= IDLE;
         rr_ptr    <= '0;
         grant_id  <= '0;
         ack       <= '0;
         ack_rdata <= '0;
         busy      <= 1'b0;
         m_sel     <= 1'b0;
         m_wr      <= 1'b0;
         m_wdata   <= '0;
      end else begin
         state     <= state_nxt;
         rr_ptr    <= rr_ptr_nxt;
         grant_id  <= grant_id_nxt;
         ack       <= ack_nxt;
         ack_rdata <= ack_rdata_nxt;
         busy      <= busy_nxt;
         m_sel     <= m_sel_nxt;
         m_wr      <= m_wr_nxt;
         m_wdata   <= m_wdata_nxt;
      end
   end

endmodule

// File: tb/tb_reg_bus_arbiter.sv
// Directed bench for reg_bus_arbiter with a behavioural 16-bit register slave.
// Outputs are sampled 1 time unit after each rising edge; inputs change at the same point.
module tb_reg_bus_arbiter;

   localparam int NREQ = 4;
   localparam int DW   = 16;

   logic              clk;
   logic              rstn;
   logic [NREQ-1:0]   req;
   logic [NREQ-1:0]   req_wr;
   logic [NREQ*DW-1:0] req_wdata;
   logic [NREQ-1:0]   ack;
   logic [DW-1:0]     ack_rdata;
   logic              busy;
   logic [1:0]        grant_id;
   logic              m_sel;
   logic              m_wr;
   logic [DW-1:0]     m_wdata;
   logic [DW-1:0]     m_rdata;

   logic [DW-1:0]     slave_reg;

   int n_assert = 0;
   int n_fail   = 0;

   reg_bus_arbiter #(.NREQ(NREQ), .DW(DW)) dut (
      .clk       (clk),
      .rstn      (rstn),
      .req       (req),
      .req_wr    (req_wr),
      .req_wdata (req_wdata),
      .ack       (ack),
      .ack_rdata (ack_rdata),
      .busy      (busy),
      .grant_id  (grant_id),
      .m_sel     (m_sel),
      .m_wr      (m_wr),
      .m_wdata   (m_wdata),
      .m_rdata   (m_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Register slave: captures on sel&wr, drives read data combinationally on sel&~wr.
   always @(posedge clk) begin
      if (m_sel && m_wr) slave_reg <= m_wdata;
   end
   assign m_rdata = (m_sel && !m_wr) ? slave_reg : '0;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      rstn      = 1'b0;
      req       = '0;
      req_wr    = '0;
      req_wdata = '0;
      step();
      step();
      check("reset_outputs", {ack, ack_rdata, busy, grant_id, m_sel, m_wr, m_wdata}, '0);

      // Single write then read by requester 0
      rstn = 1'b1;
      req = 4'b0001; req_wr = 4'b0001; req_wdata[0 +: DW] = 16'hA5C3;
      step();
      check("wr_sel",   {m_sel, m_wr, busy}, 3'b111);
      check("wr_wdata", m_wdata, 16'hA5C3);
      check("wr_grant", grant_id, 0);
      check("wr_noack", ack, 0);
      step();
      check("wr_ack",       ack, 4'b0001);
      check("wr_ack_rdata", ack_rdata, 0);
      check("wr_sel_drop",  {m_sel, m_wr, m_wdata, busy}, {2'b00, 16'h0000, 1'b1});
      check("wr_slave",     slave_reg, 16'hA5C3);
      req = '0;
      step();
      check("wr_done", {ack, busy, m_sel}, '0);

      req = 4'b0001; req_wr = 4'b0000;
      step();
      check("rd_sel", {m_sel, m_wr, busy}, 3'b101);
      step();
      check("rd_ack",       ack, 4'b0001);
      check("rd_ack_rdata", ack_rdata, 16'hA5C3);
      check("rd_sel_drop",  m_sel, 0);
      req = '0;
      step();
      check("rd_done", {ack, ack_rdata, busy}, '0);

      // All four read requesters from reset release: order 0,1,2,3,0, acks three cycles apart
      rstn = 1'b0; req = 4'b1111; req_wr = 4'b0000;
      step();
      rstn = 1'b1;
      for (int k = 0; k < 5; k++) begin
         step();
         check($sformatf("all_grant%0d", k), {grant_id, m_sel, ack}, {2'(k % 4), 1'b1, 4'b0000});
         step();
         check($sformatf("all_ack%0d", k), {ack, ack_rdata}, {4'b0001 << (k % 4), 16'hA5C3});
         step();
         check($sformatf("all_gap%0d", k), {ack, m_sel, busy}, '0);
      end
      req = '0;

      // Serve requester 2 so the pointer sits at 3, then requesters 1 and 3 contend
      req = 4'b0100; req_wr = 4'b0100; req_wdata[2*DW +: DW] = 16'h0F0F;
      step();
      check("rr_w2_grant", {grant_id, m_wr}, {2'd2, 1'b1});
      step();
      check("rr_w2_ack", {ack, ack_rdata}, {4'b0100, 16'h0000});
      req = '0;
      step();
      req = 4'b1010; req_wr = 4'b0000;
      step();
      check("rr_first3", grant_id, 3);
      step();
      check("rr_ack3", {ack, ack_rdata}, {4'b1000, 16'h0F0F});
      step();
      step();
      check("rr_then1", grant_id, 1);
      step();
      check("rr_ack1", ack, 4'b0010);
      step();
      step();
      check("rr_from2", grant_id, 3);
      req = '0;
      step();
      check("rr_dropped_ack", ack, 4'b1000);
      step();
      check("rr_idle", {busy, ack}, '0);

      // Write data latched at grant; later change on the requester side is ignored
      req = 4'b0010; req_wr = 4'b0010; req_wdata[1*DW +: DW] = 16'h1234;
      step();
      check("latch_grant", {grant_id, m_wdata}, {2'd1, 16'h1234});
      req_wdata[1*DW +: DW] = 16'hFFFF;
      step();
      check("latch_ack",   ack, 4'b0010);
      check("latch_slave", slave_reg, 16'h1234);
      req = '0;
      step();
      req = 4'b0010; req_wr = 4'b0000;
      step();
      step();
      check("latch_readback", {ack, ack_rdata}, {4'b0010, 16'h1234});
      req = '0;
      step();

      // Reset during a read ACCESS by requester 2
      req = 4'b0100; req_wr = 4'b0000;
      step();
      check("rst_grant", {grant_id, m_sel}, {2'd2, 1'b1});
      rstn = 1'b0;
      step();
      check("rst_abort", {ack, m_sel, busy, grant_id}, '0);
      rstn = 1'b1; req = 4'b0110;
      step();
      check("rst_rrptr0", grant_id, 1);
      req = '0;
      step();
      check("rst_after_ack", ack, 4'b0010);
      step();

      // Idle quiet
      for (int c = 0; c < 20; c++) begin
         step();
         check($sformatf("quiet%0d", c), {m_sel, m_wr, m_wdata, ack, busy}, '0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/reg_bus_arbiter.md
Name: reg_bus_arbiter

Overview:
- Round-robin arbiter and access sequencer that shares one 16-bit register slave among NREQ requesters.
- Slave behaviour: writes wdata on the clock edge when sel&wr; drives rdata combinationally when sel&~wr, else 0.
- Block sits between requesters and the slave's sel/wr/wdata/rdata pins. It serialises accesses, latches each transaction, and returns a one-cycle ack with read data.

Parameters:
NREQ, 4, number of requesters (2..8)
DW, 16, data width of the slave register

Ports:
clk  input  1  clock; all logic on posedge
rstn  input  1  synchronous, active-low reset
req  input  NREQ  per-requester access request, held until ack
req_wr  input  NREQ  per-requester direction: 1 = write, 0 = read
req_wdata  input  NREQ*DW  per-requester write data; requester i uses bits [i*DW +: DW]
ack  output  NREQ  one-hot, one-cycle completion strobe to the granted requester
ack_rdata  output  DW  read data, valid only while ack is high
busy  output  1  high in ACCESS and RESP
grant_id  output  $clog2(NREQ)  index of the current or last granted requester
m_sel  output  1  slave select
m_wr  output  1  slave write enable
m_wdata  output  DW  slave write data
m_rdata  input  DW  slave read data

Behaviour:
- Reset (rstn=0 at posedge): state=IDLE; rr_ptr=0; all outputs 0 (ack, ack_rdata, busy, grant_id, m_sel, m_wr, m_wdata).
- All outputs are registered. There is no combinational path from req to any output.
- FSM IDLE:
  - If any req bit is set, pick the first set bit searching from rr_ptr upward, wrapping modulo NREQ.
  - At the same edge: latch g into grant_id; set m_sel=1, m_wr=req_wr[g], m_wdata=req_wdata[g]; set busy=1; go to ACCESS.
  - If no req bit is set, stay in IDLE with outputs at 0.
- FSM ACCESS (exactly 1 cycle, m_sel=1):
  - Write: the slave captures m_wdata at the closing edge.
  - Read: the block samples m_rdata into ack_rdata at the closing edge.
  - At that edge: set ack[grant_id]=1; clear m_sel, m_wr, m_wdata to 0; set rr_ptr=(grant_id+1) mod NREQ; go to RESP.
- FSM RESP (1 cycle):
  - ack is high for this cycle only.
  - ack_rdata holds the read value, or 0 for a write.
  - At the closing edge: ack and ack_rdata return to 0, busy returns to 0, go to IDLE.
- Latency: req seen in IDLE at cycle 0 -> m_sel high in cycle 1 -> ack in cycle 2 -> IDLE in cycle 3. Throughput is one access per 3 cycles.
- Requester protocol:
  - Drop req in the cycle after ack, or keep it high to request another access.
  - A held req is re-arbitrated in IDLE under round-robin, so it loses to any other pending requester.
- Fairness: after requester g is served, g has the lowest priority. With all NREQ requesting continuously, each is served once every 3*NREQ cycles.
- Transaction values are latched at grant:
  - Changes to req_wr or req_wdata after grant have no effect on the current access.
  - If req drops during ACCESS or RESP (protocol violation), the access still completes and ack is still issued.
- Reset mid-operation (ACCESS or RESP): abort next edge, everything returns to reset values, no ack issued. A write in progress is either committed at that same edge by the slave or not; no further slave access follows.
- m_sel is never high for more than one consecutive cycle. m_wr=1 only when m_sel=1. At most one ack bit is high at a time.
- grant_id holds its value through IDLE until the next grant.

Test Plan:
- Single write then read: req[0] write 16'hA5C3; after ack, req[0] read -> m_sel high 1 cycle each; write ack_rdata=0; read ack in cycle 2 with ack_rdata=16'hA5C3.
- Simultaneous requests: all 4 req high from reset release, each a read -> grant order 0,1,2,3,0; acks spaced exactly 3 cycles apart; ack stays one-hot.
- Round-robin wrap: rr_ptr at 3, req[1] and req[3] high -> 3 served first, then 1; next grant search starts at 2.
- Reset mid-access: assert rstn=0 during ACCESS of a read by req[2] -> no ack; m_sel=0 and busy=0 the next cycle; rr_ptr=0.
- Latched data: requester 1 changes req_wdata from 16'h1234 to 16'hFFFF one cycle after grant -> slave register reads back 16'h1234.
- Idle quiet: no req for 20 cycles -> m_sel, m_wr, m_wdata, ack, busy all stay 0.
